// File: rtl/poly_result_packer_pkg.sv
// Shared constants, FSM encoding and lane-extraction helper for the
// SABER result packer.
package poly_pack_pkg;
  localparam int COEFF_W  = 13;
  localparam int LANE_W   = 16;
  localparam int N_COEFF  = 256;
  localparam int WORD_W   = 64;
  localparam int LANES    = 4;
  localparam int GROUPS   = N_COEFF / LANES;
  localparam int N_WORDS  = N_COEFF * COEFF_W / WORD_W;
  localparam int GRP_BITS = LANES * COEFF_W;           // 52 bits appended per group
  localparam int BUF_W    = 128;                       // max fill is 63 + 52 = 115
  localparam int FILL_W   = 7;
  localparam int ADDR_W   = $clog2(N_WORDS);
  localparam int GRP_W    = $clog2(GROUPS);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_e;

  // Keep the low COEFF_W bits of each lane; lane 0 lands lowest in the stream.
  function automatic logic [GRP_BITS-1:0] pack_lanes(input logic [LANES*LANE_W-1:0] x);
    logic [GRP_BITS-1:0] r;
    r = '0;
    for (int i = 0; i < LANES; i++)
      r[i*COEFF_W +: COEFF_W] = x[i*LANE_W +: COEFF_W];
    return r;
  endfunction
endpackage

// File: rtl/poly_result_packer_if.sv
// Handshake/data bundle between the result packer, the multiplier and the
// result BRAM. master = packer side, slave = controller/multiplier/BRAM side.
interface poly_result_packer_if;
  import poly_pack_pkg::*;
  logic                      start;
  logic                      read;
  logic [LANES*LANE_W-1:0]   coeff4x_in;
  logic                      wr_en;
  logic [ADDR_W-1:0]         wr_addr;
  logic [WORD_W-1:0]         wr_data;
  logic                      busy;
  logic                      done;
  logic [WORD_W-1:0]         csum;

  modport master (input start, coeff4x_in,
                  output read, wr_en, wr_addr, wr_data, busy, done, csum);
  modport slave  (output start, coeff4x_in,
                  input read, wr_en, wr_addr, wr_data, busy, done, csum);
endinterface

// File: rtl/poly_result_packer_bit_packer.sv
// poly_bit_packer: 128-bit bit buffer that appends 52 bits per valid group at
// the current fill level and hands out the low 64 bits once fill reaches 64.
// Ports: clk, rst_n (async low), clear (start of a run), in_vld/in_data
// (one packed group), emit/word (combinational: a full word is ready now).
module poly_bit_packer
  import poly_pack_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                in_vld,
  input  logic [GRP_BITS-1:0] in_data,
  output logic                emit,
  output logic [WORD_W-1:0]   word
);
  logic [BUF_W-1:0]  buf_q, merged;
  logic [FILL_W-1:0] fill_q, fill_sum;

  always_comb begin
    merged   = buf_q;
    fill_sum = fill_q;
    if (in_vld) begin
      merged   = buf_q | (BUF_W'(in_data) << fill_q);
      fill_sum = fill_q + FILL_W'(GRP_BITS);
    end
    // Fill is below 64 between groups, so this can only fire on a valid cycle.
    emit = (fill_sum >= FILL_W'(WORD_W));
    word = merged[WORD_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q  <= '0;
      fill_q <= '0;
    end else if (clear) begin
      buf_q  <= '0;
      fill_q <= '0;
    end else if (in_vld) begin
      if (emit) begin
        buf_q  <= merged >> WORD_W;
        fill_q <= fill_sum - FILL_W'(WORD_W);
      end else begin
        buf_q  <= merged;
        fill_q <= fill_sum;
      end
    end
  end
endmodule

// File: rtl/poly_result_packer.sv
// poly_result_packer: drains 256 13-bit coefficients from the multiplier
// (four per read), packs them densely LSB-first and writes 52 x 64-bit words
// to the result BRAM.
// Ports: clk, rst_n (async low), bus (poly_result_packer_if.master: start,
//   read, coeff4x_in, wr_en, wr_addr, wr_data, busy, done, csum).
// Parameter RD_LAT: cycles from read high to coeff4x_in valid (>=1).
// Optional: POLY_PACK_CSUM_EN builds an XOR checksum of the written words;
//   without it csum is tied to 0.
module poly_result_packer
  import poly_pack_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input logic                  clk,
  input logic                  rst_n,
  poly_result_packer_if.master bus
);
  state_e             state_q, state_d;
  logic [GRP_W-1:0]   grp_q;
  logic               read, start_acc;
  logic [RD_LAT:1]    vld_q;
  logic [RD_LAT:0]    vld_pipe;
  logic               emit;
  logic [WORD_W-1:0]  word;
  logic [ADDR_W-1:0]  addr_cnt, wr_addr_q;
  logic               wr_en_q;
  logic [WORD_W-1:0]  wr_data_q;

  assign read      = (state_q == READ);
  assign start_acc = (state_q == IDLE) && bus.start;   // start while busy is dropped
  assign vld_pipe  = {vld_q, read};

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (bus.start) state_d = READ;
      READ:  if (grp_q == GRP_W'(GROUPS - 1)) state_d = DRAIN;
      // Nothing in flight means the final group already emitted its word;
      // that word's write strobe is on the bus this cycle.
      DRAIN: if (~|vld_q) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grp_q   <= '0;
      vld_q   <= '0;
    end else begin
      state_q <= state_d;
      vld_q   <= vld_pipe[RD_LAT-1:0];
      if (start_acc)    grp_q <= '0;
      else if (read)    grp_q <= grp_q + 1'b1;
    end
  end

  poly_bit_packer u_packer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (start_acc),
    .in_vld  (vld_pipe[RD_LAT]),
    .in_data (pack_lanes(bus.coeff4x_in)),
    .emit    (emit),
    .word    (word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_cnt  <= '0;
      wr_addr_q <= '0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= emit;
      if (start_acc) begin
        addr_cnt <= '0;
      end else if (emit) begin
        wr_data_q <= word;
        wr_addr_q <= addr_cnt;
        addr_cnt  <= addr_cnt + 1'b1;
      end
    end
  end

`ifdef POLY_PACK_CSUM_EN
  logic [WORD_W-1:0] csum_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        csum_q <= '0;
    else if (start_acc) csum_q <= '0;
    else if (wr_en_q)  csum_q <= csum_q ^ wr_data_q;
  end
  assign bus.csum = csum_q;
`else
  assign bus.csum = '0;
`endif

  assign bus.read    = read;
  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = (state_q == DONE);
  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
endmodule
